// File: rtl/barrel_shift_seq.sv
// Command sequencer for an external 8-bit combinational barrel shifter: buffers shift commands,
// splits large amounts into passes of at most 7 and returns results on a valid/ready port.
module barrel_shift_seq #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AMT_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [7:0]               cmd_data,
  input  logic [AMT_W-1:0]         cmd_amt,
  input  logic                     cmd_lr,
  output logic [7:0]               sh_in,
  output logic [2:0]               sh_n,
  output logic                     sh_lr,
  input  logic [7:0]               sh_out,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [7:0]               res_data,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [7:0]       acc_q, acc_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic             lr_q, lr_d;
  logic             res_valid_q;

  logic [7:0]       mem_data [DEPTH];
  logic [AMT_W-1:0] mem_amt  [DEPTH];
  logic             mem_lr   [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q;

  logic             push, pop, fifo_empty;
  logic [2:0]       step;
  logic [AMT_W-1:0] rem_next;

  assign cmd_ready  = (level_q < LW'(DEPTH));
  assign push       = cmd_valid && cmd_ready;
  assign fifo_empty = (level_q == '0);

  // Storage is not reset: only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr_q] <= cmd_data;
      mem_amt[wr_ptr_q]  <= cmd_amt;
      mem_lr[wr_ptr_q]   <= cmd_lr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push && !pop)      level_q <= level_q + LW'(1);
      else if (!push && pop) level_q <= level_q - LW'(1);
    end
  end

  always_comb begin
    step     = (rem_q > AMT_W'(7)) ? 3'd7 : rem_q[2:0];
    rem_next = rem_q - AMT_W'(step);
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    lr_d    = lr_q;
    pop     = 1'b0;
    case (state_q)
      StIdle: begin
        if (!fifo_empty) pop = 1'b1;
      end
      StShift: begin
        acc_d = sh_out;
        rem_d = rem_next;
        if (rem_next == '0) state_d = StDone;
      end
      StDone: begin
        if (res_ready) begin
          if (!fifo_empty) pop = 1'b1;
          else             state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // A pop always loads a fresh command, whether from IDLE or straight out of DONE.
    if (pop) begin
      acc_d   = mem_data[rd_ptr_q];
      rem_d   = mem_amt[rd_ptr_q];
      lr_d    = mem_lr[rd_ptr_q];
      state_d = StShift;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      rem_q       <= '0;
      lr_q        <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      rem_q       <= rem_d;
      lr_q        <= lr_d;
      res_valid_q <= (state_d == StDone);
    end
  end

  always_comb begin
    sh_in      = acc_q;
    sh_n       = (state_q == StShift) ? step : 3'd0;
    sh_lr      = lr_q;
    res_valid  = res_valid_q;
    res_data   = acc_q;
    busy       = (state_q != StIdle);
    fifo_level = level_q;
  end

endmodule

// File: tb/tb_barrel_shift_seq.sv
// Self-checking bench for barrel_shift_seq; models the external shifter and predicts results
// from the plain arithmetic meaning of a logical shift.
module tb_barrel_shift_seq;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AMT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [7:0]       cmd_data = '0;
  logic [AMT_W-1:0] cmd_amt = '0;
  logic             cmd_lr = 1'b0;
  logic [7:0]       sh_in;
  logic [2:0]       sh_n;
  logic             sh_lr;
  logic [7:0]       sh_out;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [7:0]       res_data;
  logic             busy;
  logic [$clog2(DEPTH):0] fifo_level;

  int checks = 0;
  int errors = 0;

  barrel_shift_seq #(.DEPTH(DEPTH), .AMT_W(AMT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .cmd_amt(cmd_amt), .cmd_lr(cmd_lr),
    .sh_in(sh_in), .sh_n(sh_n), .sh_lr(sh_lr), .sh_out(sh_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  // External combinational shifter.
  assign sh_out = sh_lr ? (sh_in << sh_n) : (sh_in >> sh_n);

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] ref_shift(input logic [7:0] d, input int amt, input logic lr);
    int v;
    if (amt >= 8) return 8'h00;
    v = int'(d);
    v = lr ? (v << amt) : (v >> amt);
    return v[7:0];
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++; if (fifo_level !== 0) begin errors++; $display("FAIL reset_level got %0d want 0", fifo_level); end
    checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin errors++;
      $display("FAIL reset_flags got valid=%b busy=%b want 0 0", res_valid, busy); end
    checks++; if ({sh_in, sh_n, sh_lr, res_data} !== 20'h0) begin errors++;
      $display("FAIL reset_outs got in=%h n=%0d lr=%b data=%h want all 0", sh_in, sh_n, sh_lr, res_data); end
    step_clk();
    step_clk();
    rst_n = 1'b1;
    #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", cmd_ready); end
  endtask

  task automatic run_single(input logic [7:0] d, input int amt, input logic lr, input string tag);
    logic [7:0] acc_m;
    int rem, stp, p;
    cmd_data = d; cmd_amt = amt[AMT_W-1:0]; cmd_lr = lr; cmd_valid = 1'b1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL %s ready got %b want 1", tag, cmd_ready); end
    step_clk();
    cmd_valid = 1'b0;
    checks++; if (fifo_level !== 1) begin errors++; $display("FAIL %s level got %0d want 1", tag, fifo_level); end
    step_clk();
    acc_m = d; rem = amt; p = (amt == 0) ? 1 : (amt + 6) / 7;
    for (int k = 0; k < p; k++) begin
      stp = (rem > 7) ? 7 : rem;
      checks++;
      if (sh_in !== acc_m || sh_n !== 3'(stp) || sh_lr !== lr || res_valid !== 1'b0) begin errors++;
        $display("FAIL %s pass%0d got in=%h n=%0d lr=%b v=%b want in=%h n=%0d lr=%b v=0",
                 tag, k, sh_in, sh_n, sh_lr, res_valid, acc_m, stp, lr); end
      acc_m = lr ? (acc_m << stp) : (acc_m >> stp);
      rem   = rem - stp;
      step_clk();
    end
    checks++; if (res_valid !== 1'b1 || res_data !== ref_shift(d, amt, lr)) begin errors++;
      $display("FAIL %s result got v=%b d=%h want v=1 d=%h", tag, res_valid, res_data, ref_shift(d, amt, lr)); end
    step_clk();
    checks++; if (res_valid !== 1'b1 || res_data !== ref_shift(d, amt, lr)) begin errors++;
      $display("FAIL %s hold got v=%b d=%h want v=1 d=%h", tag, res_valid, res_data, ref_shift(d, amt, lr)); end
    res_ready = 1'b1;
    step_clk();
    res_ready = 1'b0;
    checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin errors++;
      $display("FAIL %s after_hs got v=%b busy=%b want 0 0", tag, res_valid, busy); end
  endtask

  task automatic test_single_pass();
    run_single(8'h81, 1, 1'b1, "single");
  endtask

  task automatic test_multi_pass();
    run_single(8'h01, 15, 1'b1, "multi15");
    run_single(8'hFF, 9, 1'b0, "multi9");
  endtask

  task automatic test_back_to_back();
    int cyc;
    res_ready = 1'b1;
    cmd_data = 8'hF0; cmd_amt = 4'd3; cmd_lr = 1'b0; cmd_valid = 1'b1;
    step_clk();
    cmd_data = 8'hA5; cmd_amt = 4'd0; cmd_lr = 1'b1;
    step_clk();
    cmd_valid = 1'b0;
    cyc = 0;
    while (res_valid !== 1'b1 && cyc < 10) begin step_clk(); cyc++; end
    checks++; if (res_valid !== 1'b1 || res_data !== 8'h1E) begin errors++;
      $display("FAIL b2b_first got v=%b d=%h want v=1 d=1e", res_valid, res_data); end
    step_clk();
    checks++; if (res_valid !== 1'b0 || sh_n !== 3'd0 || sh_in !== 8'hA5 || busy !== 1'b1) begin errors++;
      $display("FAIL b2b_pass got v=%b n=%0d in=%h busy=%b want v=0 n=0 in=a5 busy=1",
               res_valid, sh_n, sh_in, busy); end
    step_clk();
    checks++; if (res_valid !== 1'b1 || res_data !== 8'hA5) begin errors++;
      $display("FAIL b2b_second got v=%b d=%h want v=1 d=a5", res_valid, res_data); end
    step_clk();
    res_ready = 1'b0;
    checks++; if (busy !== 1'b0 || res_valid !== 1'b0) begin errors++;
      $display("FAIL b2b_idle got busy=%b v=%b want 0 0", busy, res_valid); end
  endtask

  task automatic test_backpressure();
    logic [7:0] q[$];
    logic [7:0] d, exp_d;
    int amt, cyc, got;
    res_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom); amt = int'($urandom_range(0, 15));
      cmd_data = d; cmd_amt = amt[AMT_W-1:0]; cmd_lr = 1'($urandom); cmd_valid = 1'b1;
      if (cmd_ready === 1'b1) q.push_back(ref_shift(d, amt, cmd_lr));
      step_clk();
    end
    cmd_valid = 1'b0;
    checks++; if (q.size() != 5) begin errors++; $display("FAIL bp_accepted got %0d want 5", q.size()); end
    checks++; if (cmd_ready !== 1'b0 || fifo_level !== 4) begin errors++;
      $display("FAIL bp_full got ready=%b level=%0d want 0 4", cmd_ready, fifo_level); end
    cyc = 0;
    while (res_valid !== 1'b1 && cyc < 20) begin step_clk(); cyc++; end
    exp_d = (q.size() > 0) ? q[0] : 8'h00;
    for (int k = 0; k < 3; k++) begin
      checks++; if (res_valid !== 1'b1 || res_data !== exp_d) begin errors++;
        $display("FAIL bp_stall%0d got v=%b d=%h want v=1 d=%h", k, res_valid, res_data, exp_d); end
      step_clk();
    end
    res_ready = 1'b1;
    got = 0; cyc = 0;
    while (got < 5 && cyc < 100) begin
      if (res_valid === 1'b1) begin
        exp_d = (q.size() > 0) ? q.pop_front() : 8'hxx;
        checks++; if (res_data !== exp_d) begin errors++;
          $display("FAIL bp_drain%0d got %h want %h", got, res_data, exp_d); end
        got++;
      end
      step_clk(); cyc++;
    end
    res_ready = 1'b0;
    checks++; if (got != 5) begin errors++; $display("FAIL bp_count got %0d want 5", got); end
    step_clk(); step_clk();
    checks++; if (res_valid !== 1'b0 || fifo_level !== 0 || busy !== 1'b0) begin errors++;
      $display("FAIL bp_empty got v=%b level=%0d busy=%b want 0 0 0", res_valid, fifo_level, busy); end
  endtask

  task automatic test_reset_mid();
    int seen;
    cmd_data = 8'h01; cmd_amt = 4'd15; cmd_lr = 1'b1; cmd_valid = 1'b1;
    step_clk();
    cmd_data = 8'h3C; cmd_amt = 4'd2;
    step_clk();
    cmd_data = 8'hC3; cmd_amt = 4'd4;
    step_clk();
    cmd_valid = 1'b0;
    checks++; if (busy !== 1'b1 || fifo_level !== 2 || sh_n !== 3'd7) begin errors++;
      $display("FAIL rmid_pre got busy=%b level=%0d n=%0d want 1 2 7", busy, fifo_level, sh_n); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || res_valid !== 1'b0 || fifo_level !== 0) begin errors++;
      $display("FAIL rmid_async got busy=%b v=%b level=%0d want 0 0 0", busy, res_valid, fifo_level); end
    checks++; if ({sh_in, sh_n, sh_lr, res_data} !== 20'h0) begin errors++;
      $display("FAIL rmid_outs got in=%h n=%0d lr=%b d=%h want all 0", sh_in, sh_n, sh_lr, res_data); end
    step_clk(); step_clk();
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      step_clk();
      if (res_valid !== 1'b0 || fifo_level !== 0) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL rmid_after got %0d bad cycles want 0", seen); end
    run_single(8'h5A, 3, 1'b0, "rmid_new");
  endtask

  task automatic test_random_single();
    for (int i = 0; i < 8; i++)
      run_single(8'($urandom), int'($urandom_range(0, 15)), 1'($urandom), "rand_single");
  endtask

  task automatic test_random_stream();
    localparam int N = 40;
    logic [7:0] q[$];
    logic [7:0] exp_d;
    int sent, got, cyc, amt;
    sent = 0; got = 0; cyc = 0;
    while (got < N && cyc < 4000) begin
      res_ready = 1'($urandom);
      if (sent < N) begin
        cmd_valid = 1'($urandom);
        cmd_data = 8'($urandom); amt = int'($urandom_range(0, 15));
        cmd_amt = amt[AMT_W-1:0]; cmd_lr = 1'($urandom);
      end else cmd_valid = 1'b0;
      if (res_valid === 1'b1 && res_ready) begin
        exp_d = (q.size() > 0) ? q.pop_front() : 8'hxx;
        checks++; if (res_data !== exp_d) begin errors++;
          $display("FAIL stream%0d got %h want %h", got, res_data, exp_d); end
        got++;
      end
      if (cmd_valid && cmd_ready === 1'b1) begin
        q.push_back(ref_shift(cmd_data, amt, cmd_lr));
        sent++;
      end
      step_clk(); cyc++;
    end
    cmd_valid = 1'b0; res_ready = 1'b0;
    checks++; if (got != N) begin errors++; $display("FAIL stream_count got %0d want %0d", got, N); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_pass();
    test_back_to_back();
    test_multi_pass();
    test_backpressure();
    test_reset_mid();
    test_random_single();
    test_random_stream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/barrel_shift_seq.md
Name: barrel_shift_seq

Overview:
- Command sequencer that sits directly upstream of the 8-bit combinational barrel shifter.
- Buffers shift commands in a small FIFO and drives the shifter's data, amount and direction inputs.
- Feeds each shifter result back into an accumulator, so shift amounts beyond 7 are done as multiple passes.
- Returns final results on a valid/ready interface.

Parameters:
- DEPTH, 4, command FIFO depth in entries; power of 2, at least 2.
- AMT_W, 4, width of the requested shift amount (0..2^AMT_W-1).

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  FIFO can accept a command.
- cmd_data  input  8  operand.
- cmd_amt  input  AMT_W  total shift amount.
- cmd_lr  input  1  direction: 1 = left, 0 = right (logical, zero fill).
- sh_in  output  8  to shifter In.
- sh_n  output  3  to shifter n.
- sh_lr  output  1  to shifter Lr.
- sh_out  input  8  from shifter Out (combinational return).
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts result.
- res_data  output  8  final shifted value.
- busy  output  1  state != IDLE.
- fifo_level  output  $clog2(DEPTH)+1  entries currently in the FIFO.

Behaviour:
- Reset: clock is one clk; reset is asynchronous, active-low (rst_n). While rst_n=0:
  - FIFO is emptied and fifo_level=0.
  - state=IDLE; acc, rem and lr are cleared to 0.
  - res_valid=0, res_data=0, busy=0, sh_in=0, sh_n=0, sh_lr=0.
  - cmd_ready=1 once rst_n=1.
- Reset mid-operation aborts the command in flight and discards all buffered commands. No result is emitted for them.
- FIFO:
  - cmd_ready = (fifo_level < DEPTH); it does not depend on a same-cycle pop.
  - Push on cmd_valid && cmd_ready.
  - An entry pushed at edge E is not poppable before edge E+1.
  - A simultaneous push and pop leaves fifo_level unchanged.
- IDLE:
  - If the FIFO is non-empty, pop into acc, rem and lr; next state SHIFT.
- SHIFT (one pass per cycle):
  - step = (rem > 7) ? 7 : rem.
  - Drive sh_in=acc, sh_n=step, sh_lr=lr.
  - On the edge: acc <= sh_out, rem <= rem - step.
  - If rem - step == 0, next state DONE; otherwise stay in SHIFT.
  - amt=0 performs exactly one pass with sh_n=0.
  - Pass count p = max(1, ceil(amt/7)); e.g. amt 15 gives steps 7, 7, 1.
- Outside SHIFT: sh_n=0, sh_in=acc, sh_lr=lr.
- DONE:
  - res_valid=1 and res_data=acc; both hold stable until res_ready=1.
  - On the handshake: if the FIFO is non-empty, pop the next command and go to SHIFT (back-to-back, no IDLE bubble); otherwise go to IDLE.
- res_valid is registered; it is 0 in IDLE and SHIFT.
- Latency: command accepted at edge E0 -> popped at E1 -> passes at E2..E(1+p) -> res_valid high after E(1+p).
- Throughput with res_ready held high: one result every p+1 cycles.
- The block uses only the shifter's combinational result and adds no interpretation of it. Shifting by 8 or more therefore yields 0 through the passes, not by shortcut.

Test Plan:
- Reset, then cmd 0x81, amt=1, lr=1 at E0 -> sh_n=1 during the cycle after E1; res_valid after E2; res_data=0x02; busy low after the handshake.
- cmd 0xF0, amt=3, lr=0, then 0xA5, amt=0, lr=1 back-to-back, res_ready=1 -> results 0x1E then 0xA5. The second result is exactly 2 cycles after the first and used a single pass with sh_n=0.
- cmd 0x01, amt=15, lr=1 -> sh_n sequence 7, 7, 1 on consecutive cycles; acc sequence 0x80, 0x00, 0x00; res_data=0x00 after 3 passes. cmd 0xFF, amt=9, lr=0 -> steps 7, 2; result 0x00.
- Backpressure with res_ready=0 and DEPTH=4, pushing 6 commands -> 5 accepted (1 in the accumulator, 4 buffered); cmd_ready=0 and fifo_level=4. res_data stays stable while stalled. Releasing res_ready drains all 5 results in order.
- Assert rst_n=0 mid-SHIFT of an amt=15 command with 2 commands queued -> outputs clear immediately without a clock edge. After release: fifo_level=0, no res_valid, and a new command is processed normally.
